// File: rtl/alu_channel_array.sv
// alu_channel_array
//   Array of independent, fixed-latency ADD/SUB channels. Each channel accepts
//   a command when idle (or in its response cycle), holds the operands for
//   LATENCY cycles, then presents a one-cycle response code and a result that
//   stays on out_data until the next response. Commands arriving while a
//   channel is busy are discarded and counted.
//
// Ports (channel c occupies [c*W +: W] of each flattened vector)
//   clock       in   1            rising-edge clock
//   reset       in   1            synchronous, active-high
//   in_cmd      in   2*CHANNELS   0 NOP, 1 ADD, 2 SUB, 3 reserved
//   in_data1    in   WIDTH*CH     first operand
//   in_data2    in   WIDTH*CH     second operand
//   out_resp    out  2*CHANNELS   0 none, 1 success, 2 overflow, 3 invalid
//   out_data    out  WIDTH*CH     last result, held between responses
//   ch_busy     out  CHANNELS     high while the channel is computing
//   drop_count  out  8*CHANNELS   saturating count of discarded commands
module alu_channel_array #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LATENCY  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2*CHANNELS-1:0]     in_cmd,
  input  logic [WIDTH*CHANNELS-1:0] in_data1,
  input  logic [WIDTH*CHANNELS-1:0] in_data2,
  output logic [2*CHANNELS-1:0]     out_resp,
  output logic [WIDTH*CHANNELS-1:0] out_data,
  output logic [CHANNELS-1:0]       ch_busy,
  output logic [8*CHANNELS-1:0]     drop_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_ADD  = 2'd1,
    CMD_SUB  = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    RESP_NONE     = 2'd0,
    RESP_SUCCESS  = 2'd1,
    RESP_OVERFLOW = 2'd2,
    RESP_INVALID  = 2'd3
  } resp_t;

  // LATENCY is at most 15, so a 4-bit down-counter always suffices.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch

    state_t             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    cmd_t               cmd_in, cmd_q;
    logic [WIDTH-1:0]   a_q, b_q;
    resp_t              resp_q;
    logic [WIDTH-1:0]   data_q;
    logic [7:0]         drops_q;
    logic               accept, drop, done;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res_data;
    resp_t              res_resp;

    assign cmd_in = cmd_t'(in_cmd[2*c +: 2]);

    // Next-state logic. A command seen in BUSY is a drop, including on the
    // completion edge; the response cycle is free to take a new command.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      drop     = 1'b0;
      done     = 1'b0;
      case (state)
        ST_IDLE, ST_RESPOND: begin
          if (cmd_in != CMD_NOP) begin
            accept   = 1'b1;
            state_nx = ST_BUSY;
            cnt_nx   = LAT_M1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_BUSY: begin
          drop = (cmd_in != CMD_NOP);
          if (cnt == '0) begin
            done     = 1'b1;
            state_nx = ST_RESPOND;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    // Result from captured operands only.
    always_comb begin
      sum      = {1'b0, a_q} + {1'b0, b_q};
      diff     = a_q - b_q;
      res_data = '0;
      res_resp = RESP_INVALID;
      case (cmd_q)
        CMD_ADD: begin
          res_data = sum[WIDTH-1:0];
          res_resp = sum[WIDTH] ? RESP_OVERFLOW : RESP_SUCCESS;
        end
        CMD_SUB: begin
          res_data = diff;
          res_resp = (b_q > a_q) ? RESP_OVERFLOW : RESP_SUCCESS;
        end
        default: begin
          res_data = '0;
          res_resp = RESP_INVALID;
        end
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        cmd_q   <= CMD_NOP;
        a_q     <= '0;
        b_q     <= '0;
        resp_q  <= RESP_NONE;
        data_q  <= '0;
        drops_q <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (accept) begin
          cmd_q <= cmd_in;
          a_q   <= in_data1[c*WIDTH +: WIDTH];
          b_q   <= in_data2[c*WIDTH +: WIDTH];
        end
        if (done) begin
          resp_q <= res_resp;
          data_q <= res_data;
        end else begin
          resp_q <= RESP_NONE;
        end
        if (drop && (drops_q != '1)) begin
          drops_q <= drops_q + 8'd1;
        end
      end
    end

    assign out_resp[2*c +: 2]         = resp_q;
    assign out_data[c*WIDTH +: WIDTH] = data_q;
    assign ch_busy[c]                 = (state == ST_BUSY);
    assign drop_count[8*c +: 8]       = drops_q;

  end

endmodule

// File: tb/tb_alu_channel_array.sv
// tb_alu_channel_array
//   Directed bench for alu_channel_array at CHANNELS=4, WIDTH=32, LATENCY=3.
//   A vector table covers single operations with full timing checks; hand
//   sequences cover drops/saturation, simultaneous channels, back-to-back
//   accept in the response cycle, and reset abort.
module tb_alu_channel_array;

  localparam int unsigned CH  = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [2*CH-1:0] in_cmd;
  logic [W*CH-1:0] in_data1;
  logic [W*CH-1:0] in_data2;
  logic [2*CH-1:0] out_resp;
  logic [W*CH-1:0] out_data;
  logic [CH-1:0]   ch_busy;
  logic [8*CH-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  alu_channel_array #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .LATENCY  (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_cmd     (in_cmd),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .ch_busy    (ch_busy),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned ch;
    logic [1:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int unsigned c;
    logic [2*CH-1:0] er;
    int nresp;

    vecs[0]  = '{1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
    vecs[1]  = '{2, 2'd2, 32'h0000_0005, 32'h0000_0007, 2'd2, 32'hFFFF_FFFE};
    vecs[2]  = '{2, 2'd2, 32'h0000_0007, 32'h0000_0005, 2'd1, 32'h0000_0002};
    vecs[3]  = '{2, 2'd3, 32'h0000_1234, 32'h0000_0005, 2'd3, 32'h0000_0000};
    vecs[4]  = '{0, 2'd1, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h0000_0003};
    vecs[5]  = '{3, 2'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0000_0000};
    vecs[6]  = '{0, 2'd2, 32'h0000_000A, 32'h0000_000A, 2'd1, 32'h0000_0000};
    vecs[7]  = '{3, 2'd1, 32'h7FFF_FFFF, 32'h0000_0001, 2'd1, 32'h8000_0000};
    vecs[8]  = '{1, 2'd2, 32'h0000_0000, 32'h0000_0001, 2'd2, 32'hFFFF_FFFF};
    vecs[9]  = '{0, 2'd1, 32'h1234_5678, 32'h8765_4321, 2'd1, 32'h9999_9999};
    vecs[10] = '{3, 2'd2, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};

    reset    = 1'b1;
    in_cmd   = '0;
    in_data1 = '0;
    in_data2 = '0;
    tick();
    tick();
    chk("rst_resp", out_resp, '0);
    chk("rst_data", out_data, '0);
    chk("rst_busy", ch_busy, '0);
    chk("rst_drop", drop_count, '0);
    reset = 1'b0;
    tick();

    // Table-driven single operations with full timing around the response.
    for (int i = 0; i < 11; i++) begin
      c = vecs[i].ch;
      er = '0;
      er[2*c +: 2] = vecs[i].resp;
      in_cmd[2*c +: 2]   = vecs[i].cmd;
      in_data1[c*W +: W] = vecs[i].d1;
      in_data2[c*W +: W] = vecs[i].d2;
      tick();                                   // edge k: accept
      in_cmd = '0;
      in_data1[c*W +: W] = ~vecs[i].d1;         // must not affect result
      in_data2[c*W +: W] = vecs[i].d2 ^ 32'h5A5A_A5A5;
      chk($sformatf("v%0d_busy_k", i), ch_busy, 4'b0001 << c);
      tick();
      chk($sformatf("v%0d_busy_k1", i), ch_busy, 4'b0001 << c);
      tick();
      chk($sformatf("v%0d_busy_k2", i), ch_busy, 4'b0001 << c);
      chk($sformatf("v%0d_resp_k2", i), out_resp, '0);
      tick();                                   // edge k+3: response
      chk($sformatf("v%0d_resp", i), out_resp, er);
      chk($sformatf("v%0d_data", i), out_data[c*W +: W], vecs[i].data);
      chk($sformatf("v%0d_busy_k3", i), ch_busy, '0);
      tick();
      chk($sformatf("v%0d_resp_k4", i), out_resp, '0);
      chk($sformatf("v%0d_hold_k4", i), out_data[c*W +: W], vecs[i].data);
    end
    chk("drop_none_after_table", drop_count, '0);

    // ch3: command held for three edges -> one response, two drops.
    in_cmd[7:6]   = 2'd1;
    in_data1[127:96] = 32'd10;
    in_data2[127:96] = 32'd20;
    tick(); tick(); tick();
    in_cmd = '0;
    nresp = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (out_resp[7:6] != 2'd0) nresp++;
    end
    chk("drop_one_resp", nresp, 1);
    chk("drop_ch3_data", out_data[127:96], 32'd30);
    chk("drop_ch3_is2", drop_count[31:24], 8'd2);
    chk("drop_others0", drop_count[23:0], 24'd0);

    // Continuous command from idle: accept then three drops.
    in_cmd[7:6] = 2'd2;
    tick(); tick(); tick(); tick();
    chk("drop_ch3_is5", drop_count[31:24], 8'd5);
    for (int t = 0; t < 400; t++) tick();
    chk("drop_ch3_sat", drop_count[31:24], 8'd255);
    in_cmd = '0;
    for (int t = 0; t < 6; t++) tick();
    chk("drop_ch3_sat_hold", drop_count[31:24], 8'd255);
    chk("drop_idle_busy", ch_busy, '0);

    // All channels together, then ch0 re-issued in its response cycle.
    in_cmd   = 8'h55;
    in_data1 = {32'h0000_0040, 32'h0000_0300, 32'h0000_2000, 32'h0001_0000};
    in_data2 = {32'h0000_0004, 32'h0000_0030, 32'h0000_0200, 32'h0000_1000};
    tick();                                     // edge k
    in_cmd = '0;
    chk("all_busy", ch_busy, 4'hF);
    tick(); tick(); tick();                     // edge k+3
    chk("all_resp", out_resp, 8'h55);
    chk("all_data", out_data, {32'h0000_0044, 32'h0000_0330, 32'h0000_2200, 32'h0001_1000});
    in_cmd[1:0]   = 2'd2;
    in_data1[31:0] = 32'd9;
    in_data2[31:0] = 32'd4;
    tick();                                     // edge k+4: accept in RESPOND
    in_cmd = '0;
    chk("b2b_busy", ch_busy, 4'b0001);
    chk("b2b_resp_k4", out_resp, '0);
    tick(); tick();
    chk("b2b_resp_k6", out_resp, '0);
    tick();                                     // edge k+7
    chk("b2b_resp_k7", out_resp, 8'h01);
    chk("b2b_data_k7", out_data, {32'h0000_0044, 32'h0000_0330, 32'h0000_2200, 32'h0000_0005});
    tick();

    // Reset while ch0 busy, with commands on every channel during reset.
    in_cmd[1:0]    = 2'd1;
    in_data1[31:0] = 32'd1;
    in_data2[31:0] = 32'd1;
    tick();                                     // edge k: accept
    in_cmd = '0;
    tick();
    chk("abort_busy_pre", ch_busy, 4'b0001);
    reset  = 1'b1;
    in_cmd = 8'h55;
    tick(); tick();
    chk("abort_resp", out_resp, '0);
    chk("abort_data", out_data, '0);
    chk("abort_busy", ch_busy, '0);
    chk("abort_drop", drop_count, '0);
    in_cmd = '0;
    reset  = 1'b0;
    nresp = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_resp != '0 || ch_busy != '0) nresp++;
    end
    chk("abort_no_resp", nresp, 0);
    chk("abort_drop_after", drop_count, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_channel_array.md
ALU_CHANNEL_ARRAY -- requirements
Module: alu_channel_array

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent ALU channels (1..16).
REQ-002 Parameter WIDTH, default 32, operand/result width in bits (8..64).
REQ-003 Parameter LATENCY, default 3, cycles from command accept to response (1..15).
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_cmd  input  2*CHANNELS  per-channel command: 0 NOP, 1 ADD, 2 SUB, 3 reserved (invalid).
REQ-007 in_data1  input  WIDTH*CHANNELS  per-channel first operand.
REQ-008 in_data2  input  WIDTH*CHANNELS  per-channel second operand.
REQ-009 out_resp  output  2*CHANNELS  per-channel response: 0 NO_RESPONSE, 1 SUCCESS, 2 OVERFLOW, 3 INVALID_CMD.
REQ-010 out_data  output  WIDTH*CHANNELS  per-channel result.
REQ-011 ch_busy  output  CHANNELS  per-channel busy flag.
REQ-012 drop_count  output  8*CHANNELS  per-channel count of dropped commands.
REQ-013 Channel c SHALL occupy bits [c*W +: W] of each flattened vector, W its field width.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, BUSY, RESPOND; no shared state between channels.
REQ-015 Accept: at an edge where state is IDLE or RESPOND and in_cmd != NOP, channel SHALL capture cmd, data1, data2 and enter BUSY with latency counter = LATENCY-1.
REQ-016 BUSY: counter decrements each edge; at the edge where counter is 0, channel SHALL register result into out_data/out_resp and enter RESPOND.
REQ-017 Accept at edge k SHALL produce out_resp != 0 from edge k+LATENCY for exactly one cycle.
REQ-018 RESPOND without new accept SHALL go to IDLE; out_resp SHALL return to NO_RESPONSE at next edge.
REQ-019 Accept in RESPOND SHALL be legal; back-to-back throughput is one operation per LATENCY+1 cycles.
REQ-020 out_data SHALL hold last result until next response; not cleared after response cycle.
REQ-021 ch_busy SHALL be 1 exactly while state is BUSY.
REQ-022 ADD: out_data = (data1+data2) mod 2^WIDTH; out_resp OVERFLOW if carry out, else SUCCESS.
REQ-023 SUB: out_data = (data1-data2) mod 2^WIDTH; out_resp OVERFLOW if data2 > data1 (unsigned), else SUCCESS.
REQ-024 cmd 3: out_data = 0, out_resp INVALID_CMD, same LATENCY as valid commands.
REQ-025 Operands SHALL be those captured at accept; input changes during BUSY SHALL not affect result.
REQ-026 in_cmd != NOP while BUSY SHALL be ignored and increment drop_count, saturating at 255.
REQ-027 NOP SHALL never accept or count as dropped.
REQ-028 All channels accepting on the same edge SHALL respond on the same edge with no interaction.

Reset
REQ-029 Reset SHALL set all FSMs to IDLE, out_resp 0, out_data 0, ch_busy 0, drop_count 0, counters 0.
REQ-030 Reset SHALL take priority over any command on the same edge; command is neither accepted nor dropped.
REQ-031 Reset during BUSY SHALL abort the operation; no response SHALL be emitted for it afterwards.

Verification (CHANNELS=4, WIDTH=32, LATENCY=3)
REQ-032 ch0 ADD accepted, reset asserted 2 cycles while BUSY -> all outputs 0, no ch0 response in following 10 cycles.
REQ-033 ch1 ADD 0xFFFF_FFFF + 0x0000_0001 at edge k -> ch_busy[1]=1 edges k..k+2, at k+3 out_resp OVERFLOW, out_data 0x0000_0000; at k+4 NO_RESPONSE, data held.
REQ-034 ch2 SUB 5 - 7 -> OVERFLOW, 0xFFFF_FFFE; SUB 7 - 5 -> SUCCESS, 0x0000_0002; cmd 3 -> INVALID_CMD, 0x0000_0000.
REQ-035 ch3 ADD then ADD on next two cycles -> one response only, drop_count[3]=2; 300 busy-time commands -> drop_count[3]=255.
REQ-036 All four channels ADD same edge, distinct operands -> four correct responses on same edge k+3; new ch0 command in response cycle -> second ch0 response at k+7.
